// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and helpers for the multiport register file
//   ZERO_REG  : index of the hardwired-zero register
//   calc_aw   : register address width for a given register count
//   slice_lo  : low bit of port i inside a flattened per-port vector
package rf_pkg;

    localparam int ZERO_REG = 0;

    function automatic int calc_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/multiport_register_file_if.sv
// rtl/multiport_register_file_if.sv - read, write-back and issue bus of the register file
//   rd_addr/rd_data/rd_busy : NRD combinational read ports (flattened, port i at [i*W +: W])
//   wr_en/wr_addr/wr_data   : NWR write-back ports
//   iss_en/iss_addr         : issue strobe marking a destination busy
//   busy_vec                : full scoreboard
//   master = pipeline side, slave = register file
interface multiport_register_file_if
    import rf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) ();
    localparam int AW = calc_aw(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy flags tracking in-flight producers
//   clk, rst  : clock, synchronous active-high reset (clears every flag)
//   wr_en/wr_addr : write-backs, each clears the flag of its address
//   iss_en/iss_addr : issue, sets the flag of its address (wins over a clear)
//   busy_vec  : current flags, bit 0 always 0
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NWR   = 2,
    parameter int AW    = calc_aw(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic [NREGS-1:0]  busy_vec
);
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[slice_lo(j, AW) +: AW]] = 1'b0;
            end
        end
        // Applied after the clears: a same-cycle issue is a newer producer.
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;
endmodule

// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - multi-port register file with busy scoreboard
//   clk, rst : clock, synchronous active-high reset (regs cleared, reg[SP_INDEX]=SP_RESET)
//   bus      : multiport_register_file_if.slave (reads, write-backs, issue, busy_vec)
//   Optional macro REGFILE_BYPASS_EN: reads forward same-cycle write-back data
//   and report not-busy for the forwarded port.
module multiport_register_file
    import rf_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int SP_INDEX = 2,
    parameter int SP_RESET = 2048
) (
    input logic                       clk,
    input logic                       rst,
    multiport_register_file_if.slave  bus
);
    localparam int AW = calc_aw(NREGS);

    logic [XLEN-1:0]     regs [NREGS];
    logic [NREGS-1:0]    busy;
    logic [NRD*XLEN-1:0] rd_data_c;
    logic [NRD-1:0]      rd_busy_c;

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .busy_vec (busy)
    );

    // Ports are applied in ascending order so the highest index lands last.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= (r == SP_INDEX) ? XLEN'(SP_RESET) : '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[j] && (bus.wr_addr[slice_lo(j, AW) +: AW] != AW'(ZERO_REG))) begin
                    regs[bus.wr_addr[slice_lo(j, AW) +: AW]] <= bus.wr_data[slice_lo(j, XLEN) +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int i = 0; i < NRD; i++) begin
            if (bus.rd_addr[slice_lo(i, AW) +: AW] != AW'(ZERO_REG)) begin
                rd_data_c[slice_lo(i, XLEN) +: XLEN] = regs[bus.rd_addr[slice_lo(i, AW) +: AW]];
                rd_busy_c[i] = busy[bus.rd_addr[slice_lo(i, AW) +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (bus.wr_en[j] &&
                        (bus.wr_addr[slice_lo(j, AW) +: AW] == bus.rd_addr[slice_lo(i, AW) +: AW])) begin
                        rd_data_c[slice_lo(i, XLEN) +: XLEN] = bus.wr_data[slice_lo(j, XLEN) +: XLEN];
                        rd_busy_c[i] = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.busy_vec = busy;
endmodule
